// File: rtl/addsub_rr_arbiter_if.sv
// addsub_rr_arbiter_if: request/response bus between issuing units, addsub_rr_arbiter and the consumer
interface addsub_rr_arbiter_if #(parameter int WIDTH = 4);
  logic req0_valid, req0_ready, req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic req1_valid, req1_ready, req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH:0] rsp_result;
  modport master(
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
  );
  modport slave(
    input req0_valid, req0_op, req0_a, req0_b,
    input req1_valid, req1_op, req1_a, req1_b,
    input rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin shared add/sub with single-entry result register; ADDSUB_STATS_EN adds cnt0/cnt1
module addsub_rr_arbiter #(
  parameter int WIDTH = 4
`ifdef ADDSUB_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input logic clk,
  input logic rst_n,
`ifdef ADDSUB_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  addsub_rr_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic last_grant, gnt, any, free, accept, op, c, rsp_id;
  logic [WIDTH-1:0] a, b, bx, s;
  logic [WIDTH:0] rsp_result;
  always_comb begin
    any = bus.req0_valid | bus.req1_valid;
    free = (state == EMPTY) | bus.rsp_ready;
    gnt = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept = any & free & rst_n;
    state_n = accept ? FULL : (bus.rsp_ready ? EMPTY : state);
    op = gnt ? bus.req1_op : bus.req0_op;
    a = gnt ? bus.req1_a : bus.req0_a;
    b = gnt ? bus.req1_b : bus.req0_b;
    bx = b ^ {WIDTH{op}};
    c = op;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ bx[i] ^ c;
      c = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
  end
  assign bus.req0_ready = accept & ~gnt;
  assign bus.req1_ready = accept & gnt;
  assign bus.rsp_valid = state == FULL;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_result = rsp_result;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      last_grant <= 1'b1;
      rsp_id <= 1'b0;
      rsp_result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        last_grant <= gnt;
        rsp_id <= gnt;
        rsp_result <= {c & ~op, s};
      end
    end
`ifdef ADDSUB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (accept & ~gnt & ~&cnt0) cnt0 <= cnt0 + 1'b1;
      if (accept & gnt & ~&cnt1) cnt1 <= cnt1 + 1'b1;
    end
`endif
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter: directed self-checking bench for addsub_rr_arbiter
module tb_addsub_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  addsub_rr_arbiter_if #(.WIDTH(4)) bus();
`ifdef ADDSUB_STATS_EN
  logic [1:0] cnt0, cnt1;
  addsub_rr_arbiter #(.WIDTH(4), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .cnt0(cnt0), .cnt1(cnt1), .bus(bus));
`else
  addsub_rr_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
  endtask
  task automatic set1(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
  endtask
  task automatic rsp(input string tag, input logic id, input logic [4:0] res);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
  endtask
  task automatic rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_ready0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, "_ready1"}, 32'(bus.req1_ready), 32'(r1));
  endtask
  initial begin
    rst_n = 1'b0;
    set0(1, 0, 4'd8, 4'd4);
    set1(1, 1, 4'd8, 4'd4);
    bus.rsp_ready = 1'b1;
    rdy("rst", 0, 0);
    tick;
    tick;
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    rst_n = 1'b1;
    rdy("tie0", 1, 0);
    tick;
    rsp("add8p4", 0, 5'b01100);
    set0(1, 0, 4'd15, 4'd1);
    rdy("rr1", 0, 1);
    tick;
    rsp("sub8m4", 1, 5'b00100);
    rdy("rr2", 1, 0);
    tick;
    rsp("add15p1", 0, 5'b10000);
    set1(1, 1, 4'd3, 4'd5);
    rdy("rr3", 0, 1);
    tick;
    rsp("sub3m5", 1, 5'b01110);
    set0(1, 0, 4'd15, 4'd15);
    tick;
    rsp("add15p15", 0, 5'b11110);
    bus.rsp_ready = 1'b0;
    set1(1, 1, 4'd8, 4'd4);
    rdy("bp0", 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      set0(1, 1, 4'(i), 4'd7);
      rsp("bp_hold", 0, 5'b11110);
      rdy("bp", 0, 0);
    end
    bus.rsp_ready = 1'b1;
    rdy("bp_release", 0, 1);
    tick;
    rsp("bp_next", 1, 5'b00100);
    bus.rsp_ready = 1'b0;
    set1(0, 0, 4'd0, 4'd0);
    set0(1, 0, 4'd8, 4'd4);
    rdy("drop_try", 0, 0);
    tick;
    set0(0, 0, 4'd8, 4'd4);
    tick;
    bus.rsp_ready = 1'b1;
    set0(1, 0, 4'd8, 4'd4);
    set1(1, 1, 4'd9, 4'd1);
    rdy("drop_tie", 1, 0);
    tick;
    rsp("drop_acc", 0, 5'b01100);
    bus.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.rsp_result), 32'd0);
    chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
    rdy("mid_rst", 0, 0);
    tick;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set0(1, 0, 4'd1, 4'd2);
    rdy("post_rst_tie", 1, 0);
    tick;
    rsp("post_rst", 0, 5'b00011);
    set0(0, 0, 4'd0, 4'd0);
    set1(0, 0, 4'd0, 4'd0);
    rdy("idle", 0, 0);
    tick;
    chk("drain_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef ADDSUB_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("cnt0_rst", 32'(cnt0), 32'd0);
    rst_n = 1'b1;
    set0(1, 0, 4'd1, 4'd1);
    for (int i = 0; i < 5; i++) tick;
    set0(0, 0, 4'd0, 4'd0);
    chk("cnt0_sat", 32'(cnt0), 32'd3);
    chk("cnt1_zero", 32'(cnt1), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
